// File: rtl/conv_lif_array.sv
// rtl/conv_lif_array.sv - KxK stride-1 convolution feeding N_FMAP leaky integrate-and-fire neurons
module conv_lif_array #(
    parameter int IN_W       = 28,
    parameter int K          = 3,
    parameter int N_FMAP     = 4,
    parameter int DATA_W     = 16,
    parameter int FRAC       = 8,
    parameter int ACC_W      = 24,
    parameter int TIME_STEPS = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic signed [ACC_W-1:0]           cfg_thresh,
    input  logic [4:0]                        cfg_leak_shift,
    input  logic                              w_we,
    input  logic [$clog2(N_FMAP*K*K)-1:0]     w_addr,
    input  logic signed [DATA_W-1:0]          w_data,
    input  logic                              px_valid,
    output logic                              px_ready,
    input  logic signed [DATA_W-1:0]          px_data,
    output logic                              spk_valid,
    output logic [N_FMAP-1:0]                 spk_out,
    output logic [$clog2(IN_W-K+1)-1:0]       spk_row,
    output logic [$clog2(IN_W-K+1)-1:0]       spk_col,
    output logic [$clog2(TIME_STEPS)-1:0]     spk_t,
    output logic                              busy,
    output logic                              done
);
    localparam int OUT_W  = IN_W - K + 1;
    localparam int KK     = K * K;
    localparam int NW     = N_FMAP * KK;
    localparam int N_POS  = OUT_W * OUT_W;
    localparam int RC_W   = $clog2(IN_W);
    localparam int OC_W   = $clog2(OUT_W);
    localparam int T_W    = $clog2(TIME_STEPS);
    localparam int MA_W   = $clog2(N_POS);
    localparam int PROD_W = 2 * DATA_W;
    localparam int SUM_W  = PROD_W + $clog2(KK) + 1;
    localparam int WIDE_W = (SUM_W > ACC_W + 2) ? SUM_W : ACC_W + 2;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t state_q, state_d;

    logic signed [DATA_W-1:0] w_mem [NW];
    logic [RC_W-1:0]          row_q, col_q;
    logic [T_W-1:0]           t_q;
    logic signed [ACC_W-1:0]  thresh_q;
    logic [4:0]               leak_q;

    logic signed [DATA_W-1:0] lb_q    [K-1][IN_W];
    logic signed [DATA_W-1:0] col_vec [K];
    logic signed [DATA_W-1:0] win_q   [K][K];
    logic signed [DATA_W-1:0] win_d   [K][K];

    logic signed [PROD_W-1:0] prod_q [N_FMAP][KK];
    logic                     s1_v_q;
    logic [OC_W-1:0]          s1_row_q, s1_col_q;
    logic [T_W-1:0]           s1_t_q;

    logic signed [ACC_W-1:0]  conv_c [N_FMAP];
    logic signed [ACC_W-1:0]  conv_q [N_FMAP];
    logic                     s2_v_q;
    logic [OC_W-1:0]          s2_row_q, s2_col_q;
    logic [T_W-1:0]           s2_t_q;

    logic signed [ACC_W-1:0]  mem_q   [N_FMAP][N_POS];
    logic [MA_W-1:0]          mem_addr;
    logic [N_FMAP-1:0]        fire_c;
    logic signed [ACC_W-1:0]  v_new_c [N_FMAP];

    logic                     spk_valid_q;
    logic [N_FMAP-1:0]        spk_out_q;
    logic [OC_W-1:0]          spk_row_q, spk_col_q;
    logic [T_W-1:0]           spk_t_q;

    logic accept, last_col, last_row, last_t, frame_end, run_end, win_done, pipe_empty;

    // Clamp a wide signed value into the ACC_W membrane range.
    function automatic logic signed [ACC_W-1:0] sat(input logic signed [WIDE_W-1:0] x);
        if ((&x[WIDE_W-1:ACC_W-1]) || !(|x[WIDE_W-1:ACC_W-1]))
            return x[ACC_W-1:0];
        else if (x[WIDE_W-1])
            return {1'b1, {(ACC_W-1){1'b0}}};
        else
            return {1'b0, {(ACC_W-1){1'b1}}};
    endfunction

    assign accept     = px_valid && px_ready;
    assign last_col   = (col_q == RC_W'(IN_W - 1));
    assign last_row   = (row_q == RC_W'(IN_W - 1));
    assign last_t     = (t_q == T_W'(TIME_STEPS - 1));
    assign frame_end  = accept && last_col && last_row;
    assign run_end    = frame_end && last_t;
    assign win_done   = accept && (row_q >= RC_W'(K - 1)) && (col_q >= RC_W'(K - 1));
    assign pipe_empty = !s1_v_q && !s2_v_q && !spk_valid_q;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start)      state_d = S_RUN;
            S_RUN:   if (run_end)    state_d = S_DRAIN;
            S_DRAIN: if (pipe_empty) state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        px_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_RUN: begin
                px_ready = 1'b1;
                busy     = 1'b1;
            end
            S_DRAIN: begin
                busy = 1'b1;
                done = pipe_empty;
            end
            default: ;
        endcase
    end

    // Weight array: written only while idle and deliberately not reset so rst keeps the kernels
    always_ff @(posedge clk) begin
        if (w_we && state_q == S_IDLE) w_mem[w_addr] <= w_data;
    end

    // Frame position / time step counters and configuration latched at start
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q    <= '0;
            col_q    <= '0;
            t_q      <= '0;
            thresh_q <= '0;
            leak_q   <= '0;
        end else if (state_q == S_IDLE && start) begin
            row_q    <= '0;
            col_q    <= '0;
            t_q      <= '0;
            thresh_q <= cfg_thresh;
            leak_q   <= cfg_leak_shift;
        end else if (accept) begin
            if (last_col) begin
                col_q <= '0;
                if (last_row) begin
                    row_q <= '0;
                    t_q   <= t_q + T_W'(1);
                end else begin
                    row_q <= row_q + RC_W'(1);
                end
            end else begin
                col_q <= col_q + RC_W'(1);
            end
        end
    end

    // Column of K vertically adjacent pixels ending at the incoming one, and the shifted window
    always_comb begin
        for (int i = 0; i < K - 1; i++) col_vec[i] = lb_q[i][col_q];
        col_vec[K-1] = px_data;
        for (int kr = 0; kr < K; kr++) begin
            for (int kc = 0; kc < K - 1; kc++) win_d[kr][kc] = win_q[kr][kc+1];
            win_d[kr][K-1] = col_vec[kr];
        end
    end

    // Line buffer rows move up by one at the accepted column; window slides right
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K - 1; i++)
                for (int c = 0; c < IN_W; c++) lb_q[i][c] <= '0;
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++) win_q[kr][kc] <= '0;
        end else if (accept) begin
            for (int i = 0; i < K - 1; i++) lb_q[i][col_q] <= col_vec[i+1];
            for (int kr = 0; kr < K; kr++)
                for (int kc = 0; kc < K; kc++) win_q[kr][kc] <= win_d[kr][kc];
        end
    end

    // Stage 1: multiply the freshly completed window by every kernel
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_v_q   <= 1'b0;
            s1_row_q <= '0;
            s1_col_q <= '0;
            s1_t_q   <= '0;
            for (int f = 0; f < N_FMAP; f++)
                for (int i = 0; i < KK; i++) prod_q[f][i] <= '0;
        end else begin
            s1_v_q <= win_done;
            if (win_done) begin
                s1_row_q <= OC_W'(row_q - RC_W'(K - 1));
                s1_col_q <= OC_W'(col_q - RC_W'(K - 1));
                s1_t_q   <= t_q;
                for (int f = 0; f < N_FMAP; f++)
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++)
                            prod_q[f][kr*K+kc] <= PROD_W'(win_d[kr][kc]) * PROD_W'(w_mem[f*KK+kr*K+kc]);
            end
        end
    end

    // Adder tree, rescale to FRAC fractional bits and clamp to the membrane range
    always_comb begin
        logic signed [SUM_W-1:0] acc;
        for (int f = 0; f < N_FMAP; f++) begin
            acc = '0;
            for (int i = 0; i < KK; i++) acc = acc + SUM_W'(prod_q[f][i]);
            conv_c[f] = sat(WIDE_W'(acc >>> FRAC));
        end
    end

    // Stage 2: register the convolution results
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_v_q   <= 1'b0;
            s2_row_q <= '0;
            s2_col_q <= '0;
            s2_t_q   <= '0;
            for (int f = 0; f < N_FMAP; f++) conv_q[f] <= '0;
        end else begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_row_q <= s1_row_q;
                s2_col_q <= s1_col_q;
                s2_t_q   <= s1_t_q;
                for (int f = 0; f < N_FMAP; f++) conv_q[f] <= conv_c[f];
            end
        end
    end

    assign mem_addr = MA_W'(s2_row_q) * MA_W'(OUT_W) + MA_W'(s2_col_q);

    // LIF update; time step 0 ignores whatever the membrane memory holds from a previous run
    always_comb begin
        logic signed [ACC_W-1:0] v_old, leak, v_sum;
        fire_c = '0;
        for (int f = 0; f < N_FMAP; f++) begin
            if (s2_t_q == '0) v_old = '0;
            else              v_old = mem_q[f][mem_addr];
            if (leak_q == '0) leak = '0;
            else              leak = v_old >>> leak_q;
            v_sum     = sat(WIDE_W'(v_old) - WIDE_W'(leak) + WIDE_W'(conv_q[f]));
            fire_c[f] = (v_sum >= thresh_q);
            if (fire_c[f]) v_new_c[f] = sat(WIDE_W'(v_sum) - WIDE_W'(thresh_q));
            else           v_new_c[f] = v_sum;
        end
    end

    // Stage 3: membrane write-back (no reset, cleared lazily by the t==0 rule)
    always_ff @(posedge clk) begin
        if (!rst && s2_v_q)
            for (int f = 0; f < N_FMAP; f++) mem_q[f][mem_addr] <= v_new_c[f];
    end

    // Stage 3: spike vector and coordinates
    always_ff @(posedge clk) begin
        if (rst) begin
            spk_valid_q <= 1'b0;
            spk_out_q   <= '0;
            spk_row_q   <= '0;
            spk_col_q   <= '0;
            spk_t_q     <= '0;
        end else begin
            spk_valid_q <= s2_v_q;
            if (s2_v_q) begin
                spk_out_q <= fire_c;
                spk_row_q <= s2_row_q;
                spk_col_q <= s2_col_q;
                spk_t_q   <= s2_t_q;
            end
        end
    end

    assign spk_valid = spk_valid_q;
    assign spk_out   = spk_out_q;
    assign spk_row   = spk_row_q;
    assign spk_col   = spk_col_q;
    assign spk_t     = spk_t_q;

endmodule

// File: doc/conv_lif_array.md
Name: conv_lif_array

Overview:
- Parametrised successor to the fixed 4x4 PE convolution core.
- Streams one input frame per time step in raster order and forms KxK stride-1, no-padding windows through an internal line buffer.
- Computes N_FMAP kernel dot products per window in parallel, then applies a leaky integrate-and-fire update per feature map and output position.
- Emits one spike vector per output position per time step, and feeds the next conv/dense stage.

Parameters:
- IN_W, 28: input frame width and height, in pixels.
- K, 3: kernel size (KxK). OUT_W = IN_W-K+1.
- N_FMAP, 4: number of output feature maps (kernels).
- DATA_W, 16: signed pixel/weight width, with FRAC fractional bits.
- FRAC, 8: fractional bits of pixels, weights and membrane.
- ACC_W, 24: signed membrane/accumulator width, with FRAC fractional bits.
- TIME_STEPS, 32: frames per inference.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin inference; accepted only in IDLE
- cfg_thresh  in  ACC_W  firing threshold, sampled on accepted start
- cfg_leak_shift  in  5  leak shift, sampled on accepted start; 0 = no leak
- w_we  in  1  weight write strobe; honoured only in IDLE
- w_addr  in  clog2(N_FMAP*K*K)  index = fmap*K*K + kr*K + kc
- w_data  in  DATA_W  weight value
- px_valid  in  1  pixel valid
- px_ready  out  1  pixel ready
- px_data  in  DATA_W  pixel, raster order
- spk_valid  out  1  spike vector valid (single-cycle)
- spk_out  out  N_FMAP  spike per feature map
- spk_row, spk_col  out  clog2(OUT_W) each  output coordinate
- spk_t  out  clog2(TIME_STEPS)  time step
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last spike of the last time step

Behaviour:
- Reset: every output is 0. The FSM goes to IDLE. Counters, line buffer and pipeline are cleared. Membrane memory is cleared lazily (see next rule). Weights are not affected by rst.
- Membrane clear: a valid-bit vector, or the first-time-step rule t==0 => v_old=0, guarantees that no stale membrane state is used.
- FSM IDLE:
  - px_ready=0, busy=0.
  - w_we writes the weight array.
  - start latches the cfg inputs, clears row/col/t, and moves to RUN.
- FSM RUN:
  - px_ready=1 while pixels remain in the current frame.
  - A transfer occurs when px_valid && px_ready. px_valid without px_ready is not consumed.
  - Gaps in px_valid stall only the counters; results are unaffected.
- Window and output timing:
  - A window is complete on acceptance of pixel (r,c) with r>=K-1 and c>=K-1.
  - Output coordinate is (r-K+1, c-K+1).
  - spk_valid is asserted exactly 3 cycles after that handshake, one pulse per window.
  - Pipeline stages: window/multiply, adder tree, LIF plus membrane write.
- Frame end: after pixel (IN_W-1, IN_W-1) is accepted, t increments and row/col wrap to 0. After frame TIME_STEPS-1, px_ready drops and the FSM moves to DRAIN.
- FSM DRAIN: waits for the pipeline to empty, pulses done, and returns to IDLE. busy=1 in RUN and DRAIN.
- Arithmetic:
  - Product is 2*DATA_W bits (2*FRAC fractional bits).
  - Sum of the K*K products is arithmetically shifted right by FRAC, then saturated to ACC_W.
  - leak = (cfg_leak_shift==0) ? 0 : v_old >>> cfg_leak_shift.
  - v = sat(v_old - leak + conv).
  - spike = (v >= cfg_thresh). If spike, v = v - cfg_thresh (reset by subtraction, saturated). Store v.
  - All signed; saturation clamps to +/-(2^(ACC_W-1)) limits.
- Membrane hazard: consecutive windows address distinct membrane entries within a frame. Read-after-write between frames needs no forwarding beyond the 3-cycle pipeline, because OUT_W>=2 and there is an inter-frame gap of >=K-1 rows.
- Ignored inputs: start in RUN/DRAIN and w_we outside IDLE are ignored.
- Reset mid-operation: aborts immediately. No spk_valid or done follows. A fresh start behaves as from power-on, except that weights are retained.

Test Plan:
1. IN_W=5, K=2. fmap0 weights all 0x0100, others 0. Pixels all 1.0. thresh=2.0, leak_shift=0 -> conv=4.0; fmap0 spikes at every position every step, v=2.0 after t0 and 4.0 after t1; spk_out=4'b0001; 16 spk_valid per step; done once after 32*16 spikes.
2. fmap1 weights 0.25, pixels 1.0, thresh=2.5. leak_shift=1 -> v = 1.0, 1.5, 1.75, ..., converging to 2.0; no fmap1 spike ever. leak_shift=0 -> spike at t=2 (v=3.0 -> 0.5), next spike at t=4 (v=2.5 -> 0.0).
3. Rerun scenario 1 with px_valid randomly low 50% of cycles -> identical spike sequence and coordinates. spk_valid exactly 3 cycles after each window-completing handshake.
4. Assert rst at t=5 mid-frame -> next cycle all outputs 0, busy=0, no done. Restart with the same stimulus -> output identical to a fresh run; weights are still the ones loaded before reset.
5. In IDLE, px_valid=1 -> px_ready=0, nothing consumed. start and w_we pulsed during RUN -> no effect on outputs or weights.
6. Weights 0x7FFF, pixels 0x7FFF, thresh = max positive -> v saturates at 2^(ACC_W-1)-1 and no wrap to negative. thresh = 0 -> spike every window.
